// File: rtl/serial_pkg.sv
// Package shared by the byte serializer.
// Holds the FSM state encoding, default parameter values and a helper that
// sizes the inter-frame gap counter.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } ser_state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_GAP_CYCLES  = 1;
  localparam int DEF_COUNT_WIDTH = 16;

  // Gap counter needs at least one bit even when no gap is configured.
  function automatic int gap_cnt_width(input int gap_cycles);
    if (gap_cycles > 0) begin
      return $clog2(gap_cycles + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// byte_serializer
// Takes parallel bytes over a valid/ready handshake into a one-entry holding
// register, then shifts each byte out MSB first on data_out with write_out
// high for every frame bit. A frame only starts while the downstream
// receiver reports not-busy on status_in; once started it always completes.
// Ports:
//   clock_100KHz  clock, all logic on the rising edge
//   reset         synchronous, active-low
//   byte_in       parallel byte to send
//   byte_valid    byte_in valid (accepted when byte_ready is also 1)
//   byte_ready    holding register empty
//   status_in     receiver busy; blocks the start of a new frame
//   data_out      registered serial bit
//   write_out     registered strobe, 1 while data_out carries a frame bit
//   busy_out      1 whenever the FSM is not idle
//   sent_count    completed frames, wraps
module byte_serializer
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clock_100KHz,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic                   status_in,
  output logic                   data_out,
  output logic                   write_out,
  output logic                   busy_out,
  output logic [COUNT_WIDTH-1:0] sent_count
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int GW = gap_cnt_width(GAP_CYCLES);
  // bit_cnt holds the number of bits already registered onto data_out.
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] PRE_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  ser_state_t            state;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;

  logic accept;
  logic start;

  assign accept     = byte_valid & ~hold_valid;
  assign start      = (state == S_IDLE) & hold_valid & ~status_in;
  assign byte_ready = ~hold_valid;
  assign busy_out   = (state != S_IDLE);

  // Holding register: filled on a handshake, drained when a frame starts.
  // accept needs an empty hold and start a full one, so they never coincide.
  always_ff @(posedge clock_100KHz) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= byte_in;
    end else if (start) begin
      hold_valid <= 1'b0;
    end else begin
      hold_valid <= hold_valid;
    end
  end

  // Frame FSM with registered serial outputs and the completed-frame counter.
  always_ff @(posedge clock_100KHz) begin
    if (!reset) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      data_out   <= 1'b0;
      write_out  <= 1'b0;
      sent_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // MSB goes out on the load edge; the rest is pre-shifted.
            data_out  <= hold_data[DATA_WIDTH-1];
            write_out <= 1'b1;
            shift_reg <= hold_data << 1;
            bit_cnt   <= BW'(1);
            state     <= S_SHIFT;
            if (DATA_WIDTH == 1) begin
              sent_count <= sent_count + COUNT_WIDTH'(1);
            end else begin
              sent_count <= sent_count;
            end
          end else begin
            data_out  <= 1'b0;
            write_out <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (bit_cnt != LAST_BIT) begin
            data_out  <= shift_reg[DATA_WIDTH-1];
            write_out <= 1'b1;
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + BW'(1);
            // This edge registers the final bit of the frame.
            if (bit_cnt == PRE_LAST) begin
              sent_count <= sent_count + COUNT_WIDTH'(1);
            end else begin
              sent_count <= sent_count;
            end
          end else begin
            data_out  <= 1'b0;
            write_out <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            state     <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end
        end

        S_GAP: begin
          data_out  <= 1'b0;
          write_out <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          shift_reg <= '0;
          bit_cnt   <= '0;
          gap_cnt   <= '0;
          data_out  <= 1'b0;
          write_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: one default instance (8-bit,
// one gap cycle, 16-bit counter) and one with no gap and a 4-bit counter.
module tb_byte_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       status_in;
  logic       data_out;
  logic       write_out;
  logic       busy_out;
  logic [15:0] sent_count;

  // Instance B: GAP_CYCLES=0, COUNT_WIDTH=4
  logic       reset2;
  logic [7:0] byte_in2;
  logic       byte_valid2;
  logic       byte_ready2;
  logic       status_in2;
  logic       data_out2;
  logic       write_out2;
  logic       busy_out2;
  logic [3:0] sent_count2;

  byte_serializer #(.DATA_WIDTH(8), .GAP_CYCLES(1), .COUNT_WIDTH(16)) dut (
    .clock_100KHz(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .status_in(status_in), .data_out(data_out),
    .write_out(write_out), .busy_out(busy_out), .sent_count(sent_count)
  );

  byte_serializer #(.DATA_WIDTH(8), .GAP_CYCLES(0), .COUNT_WIDTH(4)) dut2 (
    .clock_100KHz(clk), .reset(reset2), .byte_in(byte_in2), .byte_valid(byte_valid2),
    .byte_ready(byte_ready2), .status_in(status_in2), .data_out(data_out2),
    .write_out(write_out2), .busy_out(busy_out2), .sent_count(sent_count2)
  );

  int errors = 0;
  int checks = 0;

  // Serial monitors: collect every strobed bit and the idle run between frames.
  logic bits[$];
  int   low_run  = 0;
  int   gap_last = -1;
  logic bits2[$];
  int   low_run2 = 0;
  int   gap_min2 = 1000;
  int   gap_max2 = -1;

  always @(negedge clk) begin
    if (write_out === 1'b1) begin
      if (bits.size() > 0 && low_run > 0) gap_last = low_run;
      low_run = 0;
      bits.push_back(data_out);
    end else begin
      low_run++;
    end
  end

  always @(negedge clk) begin
    if (write_out2 === 1'b1) begin
      if (bits2.size() > 0 && low_run2 > 0) begin
        if (low_run2 < gap_min2) gap_min2 = low_run2;
        if (low_run2 > gap_max2) gap_max2 = low_run2;
      end
      low_run2 = 0;
      bits2.push_back(data_out2);
    end else begin
      low_run2++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] frame_a(input int k);
    logic [7:0] b = 8'h00;
    for (int j = 0; j < 8; j++) b = {b[6:0], bits[k*8+j]};
    return b;
  endfunction

  function automatic logic [7:0] frame_b(input int k);
    logic [7:0] b = 8'h00;
    for (int j = 0; j < 8; j++) b = {b[6:0], bits2[k*8+j]};
    return b;
  endfunction

  // Offer a byte on instance A and hold it until the handshake completes.
  task automatic offer(input logic [7:0] b, output logic ok);
    ok = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (byte_ready === 1'b1) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    byte_valid = 1'b0;
  endtask

  // Wait (bounded) until instance A has emitted n bits.
  task automatic wait_bits(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bits.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; status_in = 1'b0;
    step(); step();
    reset = 1'b1;
    checks++;
    if (byte_ready !== 1'b1 || write_out !== 1'b0 || data_out !== 1'b0 ||
        busy_out !== 1'b0 || sent_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b wr=%b d=%b busy=%b cnt=%0d, need 1 0 0 0 0",
               byte_ready, write_out, data_out, busy_out, sent_count);
    end
  endtask

  task automatic test_single();
    logic ok;
    bits.delete();
    byte_in = 8'hA5; byte_valid = 1'b1;
    step();                      // accept edge n
    byte_valid = 1'b0;
    checks++;
    if (byte_ready !== 1'b0 || write_out !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: ready=%b wr=%b, need 0 0", byte_ready, write_out);
    end
    step();                      // edge n+1: MSB visible
    checks++;
    if (write_out !== 1'b1 || data_out !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: wr=%b d=%b, need 1 1", write_out, data_out);
    end
    wait_bits(8, ok);
    checks++;
    if (!ok || bits.size() != 8 || frame_a(0) !== 8'hA5) begin
      errors++;
      $display("FAIL single_frame: nbits=%0d byte=%h, need 8 a5", bits.size(),
               (bits.size() >= 8) ? frame_a(0) : 8'hxx);
    end
    checks++;
    if (sent_count !== 16'd1 || write_out !== 1'b0 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL single_end: cnt=%0d wr=%b busy=%b, need 1 0 1", sent_count, write_out, busy_out);
    end
    step();
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b, need 0", busy_out);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    bits.delete(); gap_last = -1;
    offer(8'h3C, ok);
    byte_in = 8'hC3; byte_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (byte_ready === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    checks++;
    if (!ok || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept_in_frame: ready_seen=%b busy=%b, need 1 1", ok, busy_out);
    end
    step();
    byte_valid = 1'b0;
    wait_bits(16, ok);
    step(); step();
    checks++;
    if (!ok || bits.size() != 16 || frame_a(0) !== 8'h3C || frame_a(1) !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_frames: nbits=%0d", bits.size());
    end
    checks++;
    if (gap_last != 2) begin
      errors++;
      $display("FAIL b2b_gap: got %0d idle cycles, need 2", gap_last);
    end
    checks++;
    if (sent_count !== 16'd3) begin
      errors++;
      $display("FAIL b2b_count: got %0d, need 3", sent_count);
    end
  endtask

  task automatic test_status_block();
    logic ok;
    logic saw_wr;
    bits.delete();
    status_in = 1'b1;
    offer(8'h5A, ok);
    saw_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (write_out !== 1'b0) saw_wr = 1'b1;
      step();
    end
    checks++;
    if (saw_wr || bits.size() != 0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL status_hold: wr_seen=%b nbits=%0d ready=%b, need 0 0 0",
               saw_wr, bits.size(), byte_ready);
    end
    status_in = 1'b0;
    step();
    checks++;
    if (write_out !== 1'b1 || data_out !== 1'b0) begin
      errors++;
      $display("FAIL status_release: wr=%b d=%b, need 1 0", write_out, data_out);
    end
    wait_bits(8, ok);
    checks++;
    if (!ok || frame_a(0) !== 8'h5A) begin
      errors++;
      $display("FAIL status_frame: byte=%h, need 5a", ok ? frame_a(0) : 8'hxx);
    end
  endtask

  task automatic test_hold_full();
    logic ok;
    logic rdy_seen;
    bits.delete();
    offer(8'h96, ok);
    offer(8'h0F, ok);           // sits in hold while 0x96 shifts
    byte_in = 8'hFF; byte_valid = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (byte_ready !== 1'b0) rdy_seen = 1'b1;
      step();
    end
    byte_valid = 1'b0;
    checks++;
    if (rdy_seen) begin
      errors++;
      $display("FAIL hold_full_ready: ready went 1, need 0");
    end
    wait_bits(16, ok);
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (!ok || bits.size() != 16 || frame_a(0) !== 8'h96 || frame_a(1) !== 8'h0F) begin
      errors++;
      $display("FAIL hold_full_frames: nbits=%0d, need 16 frames 96 0f", bits.size());
    end
    checks++;
    if (sent_count !== 16'd6) begin
      errors++;
      $display("FAIL hold_full_count: got %0d, need 6", sent_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    int n_at_reset;
    bits.delete();
    offer(8'h81, ok);
    offer(8'h7E, ok);           // held byte that must be discarded
    wait_bits(3, ok);
    reset = 1'b0;
    step();
    checks++;
    if (write_out !== 1'b0 || sent_count !== 16'd0 || byte_ready !== 1'b1 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: wr=%b cnt=%0d ready=%b busy=%b, need 0 0 1 0",
               write_out, sent_count, byte_ready, busy_out);
    end
    reset = 1'b1;
    step();
    n_at_reset = bits.size();
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (!ok || n_at_reset >= 8 || bits.size() != n_at_reset || sent_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_abort: bits %0d->%0d cnt=%0d, need <8, unchanged, 0",
               n_at_reset, bits.size(), sent_count);
    end
  endtask

  task automatic test_wrap_nogap();
    logic [7:0] exp_b [17];
    logic ok;
    logic frames_ok;
    reset2 = 1'b0; byte_valid2 = 1'b0; byte_in2 = 8'h00; status_in2 = 1'b0;
    step(); step();
    reset2 = 1'b1;
    bits2.delete(); gap_min2 = 1000; gap_max2 = -1;
    for (int k = 0; k < 17; k++) begin
      exp_b[k] = 8'((k * 37 + 11) & 8'hFF);
      byte_in2 = exp_b[k]; byte_valid2 = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (byte_ready2 === 1'b1) begin step(); break; end
        step();
      end
      byte_valid2 = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bits2.size() >= 136) begin ok = 1'b1; break; end
      step();
    end
    step(); step();
    checks++;
    if (!ok || sent_count2 !== 4'd1) begin
      errors++;
      $display("FAIL wrap_count: got %0d, need 1", sent_count2);
    end
    frames_ok = ok && (bits2.size() == 136);
    if (frames_ok) begin
      for (int k = 0; k < 17; k++) if (frame_b(k) !== exp_b[k]) frames_ok = 1'b0;
    end
    checks++;
    if (!frames_ok) begin
      errors++;
      $display("FAIL nogap_frames: nbits=%0d, need 136 matching", bits2.size());
    end
    checks++;
    if (gap_min2 != 1 || gap_max2 != 1) begin
      errors++;
      $display("FAIL nogap_gap: min=%0d max=%0d, need 1 1", gap_min2, gap_max2);
    end
  endtask

  initial begin
    reset2 = 1'b0; byte_valid2 = 1'b0; byte_in2 = 8'h00; status_in2 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_status_block();
    test_hold_full();
    test_reset_mid_frame();
    test_wrap_nogap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
